imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, byte width delivered by the JTAG receive stage.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, byte address width from the JTAG receive stage.
REQ-003 SHALL have parameter WORD_WIDTH, default 32, instruction memory data width, equal to 4*BIT_WIDTH.
REQ-004 SHALL have clk_i  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-005 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have sel_i  input  1  JTAG user-instruction active, asynchronous (TCK domain).
REQ-007 SHALL have we_i  input  1  byte-valid level from the receive stage, high for one or more cycles per byte.
REQ-008 SHALL have data_i  input  BIT_WIDTH  received byte.
REQ-009 SHALL have addr_i  input  ADDR_WIDTH  byte address of data_i.
REQ-010 SHALL have mem_req_o  output  1  memory write request.
REQ-011 SHALL have mem_gnt_i  input  1  memory grant; a write transfers on a cycle with req and gnt both high.
REQ-012 SHALL have mem_addr_o  output  ADDR_WIDTH-2  word address.
REQ-013 SHALL have mem_wdata_o  output  WORD_WIDTH  write data, little-endian byte lanes.
REQ-014 SHALL have mem_be_o  output  4  byte enables.
REQ-015 SHALL have cpu_rst_no  output  1  active-low core reset, asserted while loading.
REQ-016 SHALL have busy_o  output  1  high in any state except IDLE.
REQ-017 SHALL have err_o  output  1  sticky overflow flag.
REQ-018 SHALL have word_cnt_o  output  ADDR_WIDTH-1  memory writes completed in the current session.

Function
REQ-019 SHALL synchronise sel_i through two flops (ASYNC_REG) to sel_s; no other input is synchronised.
REQ-020 SHALL accept a byte only on the cycle after a rising edge of we_i; a long we_i high accepts exactly one byte.
REQ-021 SHALL place an accepted byte in lane addr_i[1:0] of the assembly register and set that lane's enable bit.
REQ-022 SHALL push {addr_i[ADDR_WIDTH-1:2], data, be} into the write FIFO when lane 3 is accepted, then clear the enables.
REQ-023 SHALL push the partial word first, then start a new word, when an accepted byte's word address differs from the pending word address and any enable is set.
REQ-024 SHALL provide a 2-entry write FIFO; mem_req_o = FIFO non-empty; pop on req&&gnt; outputs driven from the FIFO head.
REQ-025 SHALL hold mem_addr/wdata/be stable while req is high and gnt is low.
REQ-026 SHALL set err_o and drop the word on a push to a full FIFO; a simultaneous pop frees the slot, so the push succeeds; err_o clears only on reset.
REQ-027 SHALL implement FSM IDLE, LOAD, FLUSH, DRAIN; the IDLE->LOAD transition is taken when sel_s is high.
REQ-028 SHALL use the transitions LOAD->FLUSH on sel_s low, FLUSH->DRAIN after one cycle, and DRAIN->IDLE when the FIFO is empty.
REQ-029 SHALL, in FLUSH, push the partial word if any enable is set; otherwise push nothing.
REQ-030 SHALL ignore we_i outside LOAD, and SHALL ignore sel_s in FLUSH and DRAIN.
REQ-031 SHALL drive cpu_rst_no as a register: 1 in IDLE, 0 in LOAD/FLUSH/DRAIN.
REQ-032 SHALL clear word_cnt_o on IDLE->LOAD, increment it per pop, and wrap modulo 2^(ADDR_WIDTH-1).

Reset
REQ-033 SHALL, while rst_ni is low, force: state IDLE, FIFO empty, assembly and enables 0, sel sync 0, we edge detector 0.
REQ-034 SHALL, while rst_ni is low, force the outputs: mem_req_o 0, mem_addr/wdata/be 0, cpu_rst_no 0, busy_o 0, err_o 0, word_cnt_o 0.
REQ-035 SHALL drive cpu_rst_no to 1 at the first clock edge after rst_ni releases, if sel_s is low.
REQ-036 SHALL discard pending data on reset mid-session; no write is issued after reset release until a new session.

Structure
REQ-037 SHALL take widths, the state enum and the FIFO depth constant from the shared package hippo_prog_pkg.
REQ-038 SHALL implement the FIFO as sub-module imem_wr_fifo (2 entries, push/pop/full/empty).

Verification
REQ-039 SHALL verify: sel high, bytes 11,22,33,44 at addr 0..3, gnt tied 1 -> one write, addr 0, wdata 0x44332211, be 0xF, word_cnt 1.
REQ-040 SHALL verify: we_i held high 5 cycles for one byte 0xAA at addr 4 -> lane 0 only; sel low -> FLUSH write, addr 1, wdata 0x000000AA, be 0x1.
REQ-041 SHALL verify: bytes at addr 0,1 then addr 8 -> write addr 0, be 0x3, then on session end write addr 2, be 0x1.
REQ-042 SHALL verify: gnt held 0, three full words pushed -> err_o 1, third word lost; gnt 1 -> exactly 2 writes.
REQ-043 SHALL verify: rst_ni low mid-LOAD with 2 bytes pending -> cpu_rst_no 0 and req 0 during reset; after release no write, and cpu_rst_no 1 within one cycle.
REQ-044 SHALL verify: sel toggled low then high during DRAIN with gnt 0 -> stays DRAIN until gnt, then IDLE, then LOAD with word_cnt 0.

Source files
------------

// File: rtl/hippo_prog_pkg.sv
// Shared constants and types for the JTAG-driven instruction memory loader.
package hippo_prog_pkg;

    localparam int BIT_WIDTH_D  = 8;
    localparam int ADDR_WIDTH_D = 10;
    localparam int LANES        = 4;
    localparam int FIFO_DEPTH   = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DRAIN
    } state_e;

    function automatic logic [LANES-1:0] lane_bit(input logic [1:0] lane);
        return LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/imem_wr_fifo.sv
// Small write FIFO between the byte assembler and the instruction memory port.
module imem_wr_fifo
    import hippo_prog_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset too, so the memory port reads all-zero during reset.
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Assembles JTAG-delivered bytes into instruction words and writes them to memory,
// holding the core in reset for the duration of a load session.
module imem_loader
    import hippo_prog_pkg::*;
#(
    parameter int BIT_WIDTH  = BIT_WIDTH_D,
    parameter int ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int WORD_WIDTH = 4 * BIT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sel_i,
    input  logic                  we_i,
    input  logic [BIT_WIDTH-1:0]  data_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-3:0] mem_addr_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    output logic [LANES-1:0]      mem_be_o,
    output logic                  cpu_rst_no,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-2:0] word_cnt_o
);

    localparam int WADDR_W = ADDR_WIDTH - 2;
    localparam int ENTRY_W = WADDR_W + WORD_WIDTH + LANES;

    (* ASYNC_REG = "TRUE" *) logic sel_meta, sel_s;

    state_e                state;
    logic                  we_q;
    logic                  acc_q;
    logic [BIT_WIDTH-1:0]  acc_data;
    logic [ADDR_WIDTH-1:0] acc_addr;

    logic [WADDR_W-1:0]    asm_addr, asm_addr_n;
    logic [WORD_WIDTH-1:0] asm_data, asm_data_n;
    logic [LANES-1:0]      asm_be, asm_be_n;
    logic                  pend_push, pend_push_n;

    logic [WADDR_W-1:0]    byte_waddr;
    logic [1:0]            byte_lane;
    logic [WORD_WIDTH-1:0] byte_word;
    logic [WORD_WIDTH-1:0] lane_mask;

    logic                  fifo_push;
    logic [ENTRY_W-1:0]    fifo_wdata;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_meta <= 1'b0;
            sel_s    <= 1'b0;
        end else begin
            sel_meta <= sel_i;
            sel_s    <= sel_meta;
        end
    end

    // we_i is already in this domain; only its rising edge is turned into one accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q     <= 1'b0;
            acc_q    <= 1'b0;
            acc_data <= '0;
            acc_addr <= '0;
        end else begin
            we_q     <= we_i;
            acc_q    <= we_i && !we_q && (state == LOAD);
            acc_data <= data_i;
            acc_addr <= addr_i;
        end
    end

    assign byte_waddr = acc_addr[ADDR_WIDTH-1:2];
    assign byte_lane  = acc_addr[1:0];
    assign byte_word  = WORD_WIDTH'(acc_data) << (byte_lane * BIT_WIDTH);
    assign lane_mask  = WORD_WIDTH'({BIT_WIDTH{1'b1}}) << (byte_lane * BIT_WIDTH);

    // A byte that evicts a partial word and also completes lane 3 needs two pushes;
    // the second is deferred one cycle via pend_push (bytes are at least two cycles apart).
    always_comb begin
        fifo_push   = 1'b0;
        fifo_wdata  = {asm_addr, asm_data, asm_be};
        asm_addr_n  = asm_addr;
        asm_data_n  = asm_data;
        asm_be_n    = asm_be;
        pend_push_n = 1'b0;
        if (pend_push || (state == FLUSH && |asm_be)) begin
            fifo_push  = 1'b1;
            asm_data_n = '0;
            asm_be_n   = '0;
        end else if (acc_q && state == LOAD) begin
            asm_addr_n = byte_waddr;
            if (|asm_be && byte_waddr != asm_addr) begin
                fifo_push   = 1'b1;
                asm_data_n  = byte_word;
                asm_be_n    = lane_bit(byte_lane);
                pend_push_n = (byte_lane == 2'd3);
            end else if (byte_lane == 2'd3) begin
                fifo_push  = 1'b1;
                fifo_wdata = {byte_waddr, (asm_data & ~lane_mask) | byte_word,
                              asm_be | lane_bit(byte_lane)};
                asm_data_n = '0;
                asm_be_n   = '0;
            end else begin
                asm_data_n = (asm_data & ~lane_mask) | byte_word;
                asm_be_n   = asm_be | lane_bit(byte_lane);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            asm_addr  <= '0;
            asm_data  <= '0;
            asm_be    <= '0;
            pend_push <= 1'b0;
        end else begin
            asm_addr  <= asm_addr_n;
            asm_data  <= asm_data_n;
            asm_be    <= asm_be_n;
            pend_push <= pend_push_n;
        end
    end

    imem_wr_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign mem_req_o = !fifo_empty;
    assign pop       = mem_req_o && mem_gnt_i;
    assign {mem_addr_o, mem_wdata_o, mem_be_o} = fifo_rdata;
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cpu_rst_no <= 1'b0;
            err_o      <= 1'b0;
            word_cnt_o <= '0;
        end else begin
            if (fifo_push && fifo_full && !pop) err_o <= 1'b1;
            if (pop) word_cnt_o <= word_cnt_o + 1'b1;
            case (state)
                IDLE: begin
                    if (sel_s) begin
                        state      <= LOAD;
                        cpu_rst_no <= 1'b0;
                        word_cnt_o <= '0;
                    end else begin
                        cpu_rst_no <= 1'b1;
                    end
                end
                LOAD:  if (!sel_s) state <= FLUSH;
                FLUSH: state <= DRAIN;
                DRAIN: begin
                    if (fifo_empty) begin
                        state      <= IDLE;
                        cpu_rst_no <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized sessions
// checked against a byte-level word-assembly model.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       we = 1'b0;
    logic       gnt = 1'b0;
    logic [7:0] data = '0;
    logic [9:0] addr = '0;

    logic        req;
    logic [7:0]  mem_addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        cpu_rst_n;
    logic        busy;
    logic        err;
    logic [8:0]  word_cnt;

    always #5 clk = ~clk;

    imem_loader #(
        .BIT_WIDTH  (8),
        .ADDR_WIDTH (10),
        .WORD_WIDTH (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sel_i       (sel),
        .we_i        (we),
        .data_i      (data),
        .addr_i      (addr),
        .mem_req_o   (req),
        .mem_gnt_i   (gnt),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (wdata),
        .mem_be_o    (be),
        .cpu_rst_no  (cpu_rst_n),
        .busy_o      (busy),
        .err_o       (err),
        .word_cnt_o  (word_cnt)
    );

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  n_pass = 0;
    int  n_total = 0;
    bit  gnt_rand = 1'b0;

    logic [7:0]  m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_be;

    // Inputs only change 1 time unit after a rising edge, so the negedge sees the
    // exact values the next rising edge will use.
    always @(negedge clk) begin
        if (rst_n && req && gnt) obs_q.push_back('{a: mem_addr, d: wdata, be: be});
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (gnt_rand) gnt = !gnt ? 1'b1 : ($urandom_range(0, 1) == 1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_emit();
        if (m_be != 4'h0) exp_q.push_back('{a: m_addr, d: m_data, be: m_be});
        m_be   = 4'h0;
        m_data = 32'h0;
    endtask

    task automatic model_byte(input logic [9:0] a, input logic [7:0] d);
        if (m_be != 4'h0 && a[9:2] != m_addr) model_emit();
        m_addr = a[9:2];
        m_data[a[1:0]*8 +: 8] = d;
        m_be[a[1:0]] = 1'b1;
        if (a[1:0] == 2'd3) model_emit();
    endtask

    task automatic send_byte(input logic [9:0] a, input logic [7:0] d, input int hold, input int gap);
        we   = 1'b1;
        addr = a;
        data = d;
        repeat (hold) step();
        we = 1'b0;
        repeat (gap) step();
    endtask

    task automatic wait_busy(input logic want, input int budget, input string name);
        for (int i = 0; i < budget && busy !== want; i++) step();
        n_total++;
        if (busy !== want) $display("FAIL %s: busy=%0b expected %0b", name, busy, want);
        else n_pass++;
    endtask

    task automatic start_session(input string name);
        sel = 1'b1;
        wait_busy(1'b1, 8, name);
        n_total++;
        if (cpu_rst_n !== 1'b0) $display("FAIL %s_cpu_rst: got %0b expected 0", name, cpu_rst_n);
        else n_pass++;
    endtask

    task automatic end_session(input string name);
        sel = 1'b0;
        wait_busy(1'b0, 200, name);
    endtask

    task automatic compare_writes(input string name);
        n_total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL %s_count: got %0d writes expected %0d", name, obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (obs_q[i].a !== exp_q[i].a || obs_q[i].d !== exp_q[i].d || obs_q[i].be !== exp_q[i].be)
                $display("FAIL %s_write%0d: got addr=%0h data=%08h be=%0h expected addr=%0h data=%08h be=%0h",
                         name, i, obs_q[i].a, obs_q[i].d, obs_q[i].be,
                         exp_q[i].a, exp_q[i].d, exp_q[i].be);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_total++;
        if ({req, mem_addr, wdata, be, cpu_rst_n, busy, err, word_cnt} !== '0)
            $display("FAIL reset_outputs: req=%0b addr=%0h wdata=%0h be=%0h cpu=%0b busy=%0b err=%0b cnt=%0d expected all 0",
                     req, mem_addr, wdata, be, cpu_rst_n, busy, err, word_cnt);
        else n_pass++;
        rst_n = 1'b1;
        n_total++;
        if (cpu_rst_n !== 1'b0) $display("FAIL reset_release_pre: cpu=%0b expected 0", cpu_rst_n);
        else n_pass++;
        step();
        n_total++;
        if (cpu_rst_n !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release: cpu=%0b busy=%0b expected 1 0", cpu_rst_n, busy);
        else n_pass++;
    endtask

    task automatic test_single_word();
        obs_q.delete();
        exp_q.delete();
        gnt = 1'b1;
        start_session("single_start");
        send_byte(10'd0, 8'h11, 1, 2);
        send_byte(10'd1, 8'h22, 1, 2);
        send_byte(10'd2, 8'h33, 1, 2);
        send_byte(10'd3, 8'h44, 1, 2);
        repeat (3) step();
        exp_q.push_back('{a: 8'h00, d: 32'h44332211, be: 4'hF});
        compare_writes("single_in_load");
        n_total++;
        if (word_cnt !== 9'd1) $display("FAIL single_word_cnt: got %0d expected 1", word_cnt);
        else n_pass++;
        end_session("single_end");
        compare_writes("single_after");
    endtask

    task automatic test_long_we();
        obs_q.delete();
        exp_q.delete();
        gnt = 1'b1;
        start_session("long_start");
        send_byte(10'd4, 8'hAA, 5, 3);
        n_total++;
        if (obs_q.size() != 0 || req !== 1'b0)
            $display("FAIL long_we_pending: got %0d writes req=%0b expected 0 0", obs_q.size(), req);
        else n_pass++;
        end_session("long_end");
        exp_q.push_back('{a: 8'h01, d: 32'h000000AA, be: 4'h1});
        compare_writes("long_we");
    endtask

    task automatic test_addr_jump();
        logic [7:0] d0, d1, d2;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        obs_q.delete();
        exp_q.delete();
        gnt = 1'b1;
        start_session("jump_start");
        send_byte(10'd0, d0, 1, 2);
        send_byte(10'd1, d1, 2, 2);
        send_byte(10'd8, d2, 1, 3);
        exp_q.push_back('{a: 8'h00, d: {16'h0, d1, d0}, be: 4'h3});
        compare_writes("jump_partial");
        end_session("jump_end");
        exp_q.push_back('{a: 8'h02, d: {24'h0, d2}, be: 4'h1});
        compare_writes("jump_flush");
    endtask

    task automatic test_overflow();
        logic [31:0] w [3];
        obs_q.delete();
        exp_q.delete();
        gnt = 1'b0;
        start_session("ovf_start");
        for (int k = 0; k < 3; k++) begin
            w[k] = $urandom;
            for (int l = 0; l < 4; l++) send_byte(10'(16 + 4 * k + l), w[k][l*8 +: 8], 1, 1);
        end
        repeat (3) step();
        n_total++;
        if (err !== 1'b1 || obs_q.size() != 0 || req !== 1'b1)
            $display("FAIL ovf_flag: err=%0b writes=%0d req=%0b expected 1 0 1", err, obs_q.size(), req);
        else n_pass++;
        gnt = 1'b1;
        repeat (6) step();
        exp_q.push_back('{a: 8'd4, d: w[0], be: 4'hF});
        exp_q.push_back('{a: 8'd5, d: w[1], be: 4'hF});
        compare_writes("ovf_drain");
        end_session("ovf_end");
        compare_writes("ovf_after");
        n_total++;
        if (err !== 1'b1) $display("FAIL ovf_sticky: err=%0b expected 1", err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        gnt = 1'b1;
        start_session("rst_start");
        send_byte(10'h20, 8'h5A, 1, 2);
        send_byte(10'h21, 8'hA5, 1, 2);
        rst_n = 1'b0;
        sel   = 1'b0;
        obs_q.delete();
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (req !== 1'b0 || cpu_rst_n !== 1'b0 || busy !== 1'b0)
                $display("FAIL rst_mid_hold: req=%0b cpu=%0b busy=%0b expected 0 0 0", req, cpu_rst_n, busy);
            else n_pass++;
        end
        rst_n = 1'b1;
        step();
        n_total++;
        if (cpu_rst_n !== 1'b1) $display("FAIL rst_mid_cpu: got %0b expected 1", cpu_rst_n);
        else n_pass++;
        repeat (10) step();
        n_total++;
        if (obs_q.size() != 0 || err !== 1'b0 || word_cnt !== 9'd0)
            $display("FAIL rst_mid_quiet: writes=%0d err=%0b cnt=%0d expected 0 0 0", obs_q.size(), err, word_cnt);
        else n_pass++;
    endtask

    task automatic test_drain_sel();
        bit saw_idle;
        obs_q.delete();
        exp_q.delete();
        gnt = 1'b0;
        start_session("drain_start");
        for (int l = 0; l < 4; l++) send_byte(10'(12 + l), 8'(8'h70 + l), 1, 1);
        repeat (2) step();
        sel = 1'b0;
        repeat (5) step();
        sel = 1'b1;
        repeat (8) step();
        n_total++;
        if (busy !== 1'b1 || req !== 1'b1 || cpu_rst_n !== 1'b0 || obs_q.size() != 0)
            $display("FAIL drain_hold: busy=%0b req=%0b cpu=%0b writes=%0d expected 1 1 0 0",
                     busy, req, cpu_rst_n, obs_q.size());
        else n_pass++;
        gnt = 1'b1;
        saw_idle = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpu_rst_n === 1'b1) saw_idle = 1'b1;
            if (saw_idle && busy === 1'b1) break;
        end
        n_total++;
        if (!saw_idle || busy !== 1'b1 || cpu_rst_n !== 1'b0 || word_cnt !== 9'd0)
            $display("FAIL drain_relaunch: idle_seen=%0b busy=%0b cpu=%0b cnt=%0d expected 1 1 0 0",
                     saw_idle, busy, cpu_rst_n, word_cnt);
        else n_pass++;
        exp_q.push_back('{a: 8'd3, d: 32'h73727170, be: 4'hF});
        compare_writes("drain");
        end_session("drain_end");
    endtask

    task automatic test_random();
        logic [9:0] a;
        logic [7:0] d;
        int         nbytes;
        gnt_rand = 1'b1;
        for (int s = 0; s < 4; s++) begin
            obs_q.delete();
            exp_q.delete();
            m_addr = '0;
            m_data = '0;
            m_be   = '0;
            start_session("rand_start");
            nbytes = $urandom_range(6, 20);
            for (int b = 0; b < nbytes; b++) begin
                a = 10'($urandom_range(0, 31));
                d = 8'($urandom);
                model_byte(a, d);
                send_byte(a, d, $urandom_range(1, 3), 3);
            end
            end_session("rand_end");
            model_emit();
            compare_writes("rand");
            n_total++;
            if (word_cnt !== 9'(exp_q.size()) || err !== 1'b0)
                $display("FAIL rand_status: cnt=%0d err=%0b expected %0d 0", word_cnt, err, exp_q.size());
            else n_pass++;
        end
        gnt_rand = 1'b0;
        gnt = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_long_we();
        test_addr_jump();
        test_overflow();
        test_reset_mid_load();
        test_drain_sel();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
